// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, defaults and helpers for the bus arbiter
//
// Contents:
//   arb_state_e      : arbiter FSM state (IDLE = no grant, OWNED = one grant)
//   NUM_REQ_DEFAULT  : default number of requesters (legal 2..8)
//   TIMEOUT_DEFAULT  : default locked-grant limit in cycles (legal 2..255)
//   onehot_to_idx()  : index of the set bit of an up-to-8-bit one-hot vector
package bus_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT = 16;

  // Zero input maps to index 0, which matches the idle owner value.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority search
//
// Ports:
//   req    [NUM_REQ-1:0]          in  : request vector
//   mask   [NUM_REQ-1:0]          in  : requesters excluded from this search (1 = excluded)
//   rr_ptr [clog2(NUM_REQ)-1:0]   in  : index where the search starts
//   winner [NUM_REQ-1:0]          out : one-hot winner, zero when nothing eligible
//   valid                         out : a winner was found
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         mask,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic                       valid
);

  logic [NUM_REQ-1:0] eligible;

  assign eligible = req & ~mask;

  // Walk NUM_REQ positions starting at rr_ptr; rr_ptr is always below
  // NUM_REQ, so a single subtraction implements the modulo wrap.
  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with lock and optional lock timeout
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN (revokes a grant held locked for TIMEOUT cycles)
//
// Ports:
//   clk                          in  : clock, all state on posedge
//   rst_n                        in  : asynchronous active-low reset
//   req   [NUM_REQ-1:0]          in  : level-sensitive bus requests
//   lock  [NUM_REQ-1:0]          in  : hold-grant qualifier, only the owner's bit matters
//   grant [NUM_REQ-1:0]          out : registered one-hot-or-zero grant
//   owner [clog2(NUM_REQ)-1:0]   out : index of grant holder, 0 when idle
//   bus_busy                     out : any grant bit high
//   timeout_err                  out : one-cycle pulse on forced revoke (0 without the macro)
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         lock,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       bus_busy,
  output logic                       timeout_err
);

  localparam int                IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("bus_arbiter: NUM_REQ must be within 2..8");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT must be within 2..255");
  end

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] excl_mask;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_valid;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   win_next_ptr;
  logic               owner_req;
  logic               owner_lock;
  logic               rearb;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] excl_q, excl_d;
  logic               terr_q, terr_d;

  // A revoked owner sits out exactly one arbitration (the cycle after revoke).
  assign excl_mask = excl_q;
`else
  assign excl_mask = '0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .mask   (excl_mask),
    .rr_ptr (rr_ptr_q),
    .winner (win_oh),
    .valid  (win_valid)
  );

  assign win_idx      = IDX_W'(onehot_to_idx(8'(win_oh)));
  assign win_next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + IDX_W'(1);
  assign owner_req    = req[owner_q];
  assign owner_lock   = lock[owner_q];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rearb    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d    = '0;
    excl_d   = '0;
    terr_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: rearb = 1'b1;
      OWNED: begin
        if (!(owner_req && owner_lock)) rearb = 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          // Forced revoke: one cycle of no grant; rr_ptr already points past
          // the revoked owner so the search resumes behind it.
          state_d = IDLE;
          grant_d = '0;
          owner_d = '0;
          terr_d  = 1'b1;
          excl_d  = grant_q;
        end
        else cnt_d = cnt_q + 8'd1;
`endif
      end
    endcase

    // rr_ptr sits one past the current owner, so in a lock-free re-arbitration
    // the owner is searched last and keeps the bus only when alone.
    if (rearb) begin
      if (win_valid) begin
        state_d  = OWNED;
        grant_d  = win_oh;
        owner_d  = win_idx;
        rr_ptr_d = win_next_ptr;
      end else begin
        state_d  = IDLE;
        grant_d  = '0;
        owner_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= |grant_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      excl_q <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      excl_q <= excl_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign bus_busy = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter (directed steps plus random traffic)
module tb_bus_arbiter;

  localparam int N = 4;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N-1:0] grant;
  logic [1:0]   owner;
  logic         bus_busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: owner as plain integer (-1 = idle).
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_excl  = -1;
  bit m_terr  = 1'b0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .lock        (lock),
    .grant       (grant),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_excl  = -1;
    m_terr  = 1'b0;
  endtask

  // One clock edge of the arbitration rules, evaluated on the inputs present at the edge.
  task automatic model_edge();
    int excl_now;
    int winner;
    int idx;
    bit arb;
    if (!rst_n) begin
      model_reset();
      return;
    end
    excl_now = m_excl;
    m_excl   = -1;
    m_terr   = 1'b0;
    arb      = 1'b0;
    winner   = -1;
    if (m_owner < 0) arb = 1'b1;
    else if (req[m_owner] && lock[m_owner]) begin
`ifdef BUS_ARB_TIMEOUT_EN
      m_cnt++;
      if (m_cnt == TO) begin
        m_excl  = m_owner;
        m_owner = -1;
        m_cnt   = 0;
        m_terr  = 1'b1;
      end
`endif
    end
    else arb = 1'b1;
    if (arb) begin
      m_cnt = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (winner < 0 && req[idx] && idx != excl_now) winner = idx;
      end
      if (winner >= 0) begin
        m_owner = winner;
        m_ptr   = (winner + 1) % N;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_grant"}, 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check({tag, "_owner"}, 32'(owner), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check({tag, "_busy"},  32'(bus_busy), 32'(m_owner >= 0));
    check({tag, "_terr"},  32'(timeout_err), 32'(m_terr));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    model_reset();
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;

    // Reset values before any clock edge
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    #1;
    check_model("rst0");
    do_reset();

    // Single requester: one-cycle latency
    step("idle");
    req = 4'b0001;
    step("first");
    check("first_grant_lit", 32'(grant), 32'h1);
    check("first_busy_lit", 32'(bus_busy), 32'h1);

    // Full rotation from rr_ptr = 0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step("rot");
      check("rot_grant_lit", 32'(grant), 32'(seq[i]));
    end

    // Owner 2 locks; lock bits of the others are ignored
    step("to2a");
    step("to2b");
    check("own2_lit", 32'(grant), 32'h4);
    lock = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      check("hold_lit", 32'(grant), 32'h4);
    end
    lock = 4'b0000;
    step("unlock");
    check("unlock_lit", 32'(grant), 32'h8);

    // Owner 3 drops req: straight to requester 0, then pointer sits at 1
    req = 4'b0001;
    step("wrap");
    check("wrap_lit", 32'(grant), 32'h1);
    req = 4'b0011;
    step("ptr1");
    check("ptr1_lit", 32'(grant), 32'h2);

    // Asynchronous reset while grant = 0010
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model("async");
    check("async_grant_lit", 32'(grant), 32'h0);
    step("inrst1");
    step("inrst2");
    rst_n = 1'b1;
    step("post_rst");
    check("post_rst_lit", 32'(grant), 32'h1);

`ifdef BUS_ARB_TIMEOUT_EN
    // Owner 1 locked for TIMEOUT cycles is revoked, requester 2 follows
    do_reset();
    req  = 4'b0110;
    lock = 4'b0010;
    step("to_grant");
    check("to_grant_lit", 32'(grant), 32'h2);
    for (int i = 0; i < TO - 1; i++) step("to_hold");
    step("to_revoke");
    check("to_revoke_grant", 32'(grant), 32'h0);
    check("to_revoke_err", 32'(timeout_err), 32'h1);
    step("to_next");
    check("to_next_grant", 32'(grant), 32'h4);
    check("to_next_err", 32'(timeout_err), 32'h0);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req  = 4'($urandom_range(0, 15));
      lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if (i == 200) rst_n = 1'b0;
      if (i == 203) rst_n = 1'b1;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
